// File: rtl/ddr_rb_pkg.sv
// Shared types and default sizes for the DDR ring-buffer controller.
//  state_e     : request sequencer states (init / idle / write / read)
//  Def*        : default widths used by the top and the read-return FIFO
package ddr_rb_pkg;

  localparam int unsigned DefDataW   = 64;
  localparam int unsigned DefAddrW   = 24;
  localparam int unsigned DefRfifoAw = 4;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StWrite,
    StRead
  } state_e;

endpackage

// File: rtl/ddr_rb_rfifo.sv
// Synchronous first-word-fall-through FIFO that holds DDR read-return data.
//  clk_i   : clock
//  rst_i   : synchronous active-high reset (empties the FIFO)
//  push_i  : write data_i (accepted when not full, or when full and popping)
//  data_i  : write data
//  pop_i   : consume data_o (ignored while empty)
//  data_o  : head word, valid whenever valid_o is high
//  valid_o : FIFO non-empty
//  count_o : number of stored words
//  ovf_o   : push refused because the FIFO was full
module ddr_rb_rfifo
  import ddr_rb_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned AW     = DefRfifoAw
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [AW:0]       count_o,
  output logic              ovf_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic              full;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    valid_o = (count_q != '0);
    full    = count_q[AW];
    do_pop  = pop_i && valid_o;
    // A pop frees the slot this cycle, so a full FIFO still takes a push.
    do_push = push_i && (!full || do_pop);
    ovf_o   = push_i && !do_push;
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    data_o  = mem_q[rptr_q];
    count_o = count_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ddr_ring_buffer_ctrl.sv
// Circular buffer in DDR2 in front of the ram_controller local interface (phy_clk domain).
// Event words arriving on in_* are written to DDR at wr_ptr; words are read back from rd_ptr and
// returned in order on out_*. One single-beat request is in flight on the local interface at a time;
// reads are only issued when the on-chip return FIFO has guaranteed room (credit), because
// local_rdata_valid cannot be stalled.
//  phy_clk / reset_phy_clk : sole clock, synchronous active-high reset
//  in_data/in_valid/in_ready    : input stream
//  out_data/out_valid/out_ready : output stream
//  local_*                      : DDR2 controller local interface
//  level     : committed words in the ring not yet issued for read
//  rdata_err : sticky, unexpected read data or return-FIFO overflow
module ddr_ring_buffer_ctrl
  import ddr_rb_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned RFIFO_AW = DefRfifoAw
) (
  input  logic                phy_clk,
  input  logic                reset_phy_clk,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                local_init_done,
  input  logic                local_ready,
  output logic [ADDR_W-1:0]   local_address,
  output logic [DATA_W-1:0]   local_wdata,
  output logic [DATA_W/8-1:0] local_be,
  output logic                local_size,
  output logic                local_burstbegin,
  output logic                local_write_req,
  output logic                local_read_req,
  input  logic [DATA_W-1:0]   local_rdata,
  input  logic                local_rdata_valid,
  output logic [ADDR_W:0]     level,
  output logic                rdata_err
);

  state_e              state_q, state_d;
  logic                last_wr_q, last_wr_d;  // last grant was a write
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [RFIFO_AW:0]   outstanding_q, outstanding_d;
  logic                err_q, err_d;

  logic [ADDR_W:0]     level_w;
  logic                ring_full;
  logic                ring_empty;
  logic [RFIFO_AW+1:0] credit_used;
  logic                rd_elig;
  logic                wr_open;
  logic                wr_grant;
  logic                rd_grant;
  logic                wr_ack;
  logic                rd_ack;
  logic                rdata_ok;
  logic                rdata_bad;
  logic [RFIFO_AW:0]   rf_count;
  logic                rf_ovf;

  ddr_rb_rfifo #(
    .DATA_W (DATA_W),
    .AW     (RFIFO_AW)
  ) u_rfifo (
    .clk_i   (phy_clk),
    .rst_i   (reset_phy_clk),
    .push_i  (rdata_ok),
    .data_i  (local_rdata),
    .pop_i   (out_ready),
    .data_o  (out_data),
    .valid_o (out_valid),
    .count_o (rf_count),
    .ovf_o   (rf_ovf)
  );

  // Eligibility and arbitration.
  always_comb begin
    level_w     = wr_ptr_q - rd_ptr_q;
    // level never exceeds 2**ADDR_W, so its top bit alone flags a full ring.
    ring_full   = level_w[ADDR_W];
    ring_empty  = (level_w == '0);
    credit_used = {1'b0, outstanding_q} + {1'b0, rf_count};
    // Credit left while outstanding + stored < 2**RFIFO_AW, i.e. both top bits clear.
    rd_elig     = !ring_empty && (credit_used[RFIFO_AW+1:RFIFO_AW] == 2'b00);
    // When both sides could go and a write was granted last, the read gets this slot.
    wr_open     = (state_q == StIdle) && !ring_full && !(rd_elig && last_wr_q);
    wr_grant    = in_valid && wr_open;
    rd_grant    = (state_q == StIdle) && rd_elig && !wr_grant;
    wr_ack      = (state_q == StWrite) && local_ready;
    rd_ack      = (state_q == StRead) && local_ready;
    rdata_ok    = local_rdata_valid && (outstanding_q != '0);
    rdata_bad   = local_rdata_valid && (outstanding_q == '0);
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    last_wr_d     = last_wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wr_ptr_d      = wr_ptr_q + (ADDR_W + 1)'(wr_ack);
    rd_ptr_d      = rd_ptr_q + (ADDR_W + 1)'(rd_ack);
    outstanding_d = outstanding_q + (RFIFO_AW + 1)'(rd_ack) - (RFIFO_AW + 1)'(rdata_ok);
    err_d         = err_q | rdata_bad | rf_ovf;

    unique case (state_q)
      StInit: begin
        if (local_init_done) state_d = StIdle;
      end
      StIdle: begin
        if (wr_grant) begin
          state_d   = StWrite;
          last_wr_d = 1'b1;
          addr_d    = wr_ptr_q[ADDR_W-1:0];
          wdata_d   = in_data;
        end else if (rd_grant) begin
          state_d   = StRead;
          last_wr_d = 1'b0;
          addr_d    = rd_ptr_q[ADDR_W-1:0];
        end
      end
      StWrite: begin
        if (local_ready) state_d = StIdle;
      end
      StRead: begin
        if (local_ready) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) begin
      state_q       <= StInit;
      last_wr_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_wr_q     <= last_wr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  // Outputs.
  always_comb begin
    in_ready         = wr_open;
    local_write_req  = (state_q == StWrite);
    local_read_req   = (state_q == StRead);
    local_burstbegin = local_write_req || local_read_req;
    local_address    = addr_q;
    local_wdata      = wdata_q;
    local_be         = '1;
    local_size       = 1'b1;
    level            = level_w;
    rdata_err        = err_q;
  end

endmodule

// File: tb/tb_ddr_ring_buffer_ctrl.sv
// Randomised bench for ddr_ring_buffer_ctrl (ADDR_W=4 so the ring can be filled and wrapped).
// A DDR model answers requests; a monitor checks requests and output data against a queue-based
// reference of the ring behaviour.
module tb_ddr_ring_buffer_ctrl;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 4;
  localparam int unsigned RAW   = 4;
  localparam int          Ring  = 2 ** AW;
  localparam int          Cred  = 2 ** RAW;

  logic          phy_clk = 1'b0;
  logic          reset_phy_clk = 1'b1;
  logic [DW-1:0] in_data = 64'd1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          local_init_done = 1'b0;
  logic          local_ready = 1'b0;
  logic [AW-1:0] local_address;
  logic [DW-1:0] local_wdata;
  logic [DW/8-1:0] local_be;
  logic          local_size;
  logic          local_burstbegin;
  logic          local_write_req;
  logic          local_read_req;
  logic [DW-1:0] local_rdata = '0;
  logic          local_rdata_valid = 1'b0;
  logic [AW:0]   level;
  logic          rdata_err;

  ddr_ring_buffer_ctrl #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .RFIFO_AW (RAW)
  ) dut (
    .phy_clk           (phy_clk),
    .reset_phy_clk     (reset_phy_clk),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .local_init_done   (local_init_done),
    .local_ready       (local_ready),
    .local_address     (local_address),
    .local_wdata       (local_wdata),
    .local_be          (local_be),
    .local_size        (local_size),
    .local_burstbegin  (local_burstbegin),
    .local_write_req   (local_write_req),
    .local_read_req    (local_read_req),
    .local_rdata       (local_rdata),
    .local_rdata_valid (local_rdata_valid),
    .level             (level),
    .rdata_err         (rdata_err)
  );

  always #5 phy_clk = ~phy_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Modes set by the main sequence, read by the driver.
  int ready_mode = 0;  // 0: always ready, 1: never, 2: random
  int out_mode   = 1;  // 0: out_ready low, 1: high, 2: random
  int in_mode    = 1;  // 0: idle, 1: stream, 2: random gaps
  int acc_limit  = 8;
  bit seq_mode   = 1'b1;
  bit hold_ret   = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } ret_t;

  // Monitor-owned reference state.
  ret_t          ret_q[$];
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] mem [Ring];
  int            lvl_m = 0;
  int            outstanding_m = 0;
  int            rf_m = 0;
  bit            err_m = 1'b0;
  logic [AW-1:0] exp_waddr = '0;
  logic [AW-1:0] exp_raddr = '0;
  int            acc_cnt = 0;
  int            rd_cnt = 0;
  bit            exp_wreq = 1'b0;
  logic [DW-1:0] exp_wreq_data;
  bit            stall_prev = 1'b0;
  logic          prev_wr, prev_rd;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;

  // Driver-owned state.
  int            cyc = 0;
  int            ret_rd = 0;
  int            seen_acc = 0;
  logic [DW-1:0] seq_next = 64'd2;

  // Inputs change 1 time unit after the rising edge.
  always @(posedge phy_clk) begin
    #1;
    cyc++;
    case (ready_mode)
      0:       local_ready = 1'b1;
      1:       local_ready = 1'b0;
      default: local_ready = ($urandom_range(0, 3) != 0);
    endcase
    case (out_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
    if (acc_cnt != seen_acc) begin
      seen_acc = acc_cnt;
      if (seq_mode) begin
        in_data  = seq_next;
        seq_next = seq_next + 64'd1;
      end else begin
        in_data = {$urandom, $urandom};
      end
    end
    in_valid = (acc_cnt < acc_limit) &&
               (in_mode == 1 || (in_mode == 2 && $urandom_range(0, 1) == 1));
    local_rdata_valid = 1'b0;
    if (!hold_ret && ret_rd < ret_q.size()) begin
      if (ret_q[ret_rd].due <= cyc && $urandom_range(0, 3) != 0) begin
        local_rdata_valid = 1'b1;
        local_rdata       = ret_q[ret_rd].data;
        ret_rd++;
      end
    end
  end

  // Values seen at the falling edge are exactly those the next rising edge will sample.
  always @(negedge phy_clk) begin
    if (reset_phy_clk) begin
      lvl_m = 0;
      outstanding_m = 0;
      rf_m = 0;
      err_m = 1'b0;
      exp_waddr = '0;
      exp_raddr = '0;
      exp_wreq = 1'b0;
      stall_prev = 1'b0;
      sb_q.delete();
      wq.delete();
    end else begin
      check(level == AW'(0) + (AW + 1)'(lvl_m), "level", level, lvl_m);
      check(rdata_err == err_m, "rdata_err", rdata_err, err_m);
      check(out_valid == (rf_m != 0), "out_valid", out_valid, rf_m != 0);
      check(outstanding_m + rf_m <= Cred, "credit", outstanding_m + rf_m, Cred);
      if (lvl_m == Ring) check(!in_ready, "full_in_ready", in_ready, 0);
      if (exp_wreq)
        check(local_write_req && local_wdata == exp_wreq_data, "wr_latency", local_wdata,
              exp_wreq_data);
      if (stall_prev)
        check(local_write_req == prev_wr && local_read_req == prev_rd &&
              local_address == prev_addr && (prev_rd || local_wdata == prev_wdata),
              "req_stable", local_address, prev_addr);

      exp_wreq = 1'b0;
      if (in_valid && in_ready) begin
        sb_q.push_back(in_data);
        wq.push_back(in_data);
        exp_wreq      = 1'b1;
        exp_wreq_data = in_data;
        acc_cnt++;
      end
      if (local_write_req && local_ready) begin
        check(wq.size() != 0, "spurious_write", wq.size(), 1);
        check(local_address == exp_waddr, "wr_addr", local_address, exp_waddr);
        if (wq.size() != 0) begin
          check(local_wdata == wq[0], "wr_data", local_wdata, wq[0]);
          void'(wq.pop_front());
        end
        mem[local_address] = local_wdata;
        exp_waddr++;
        lvl_m++;
      end
      if (local_read_req && local_ready) begin
        check(lvl_m > 0, "read_when_empty", lvl_m, 1);
        check(local_address == exp_raddr, "rd_addr", local_address, exp_raddr);
        ret_q.push_back('{data: mem[local_address], due: cyc + $urandom_range(1, 6)});
        exp_raddr++;
        lvl_m--;
        outstanding_m++;
        rd_cnt++;
      end
      if (local_rdata_valid) begin
        if (outstanding_m > 0) begin
          outstanding_m--;
          rf_m++;
        end else begin
          err_m = 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        check(sb_q.size() != 0, "spurious_out", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
          check(out_data == sb_q[0], "out_data", out_data, sb_q[0]);
          void'(sb_q.pop_front());
        end
        if (rf_m > 0) rf_m--;
      end
      stall_prev = (local_write_req || local_read_req) && !local_ready;
      prev_wr    = local_write_req;
      prev_rd    = local_read_req;
      prev_addr  = local_address;
      prev_wdata = local_wdata;
    end
  end

  task automatic wait_drained(input string name);
    int n = 0;
    while (!(acc_cnt == acc_limit && sb_q.size() == 0 && lvl_m == 0 && outstanding_m == 0 &&
             !local_write_req && !local_read_req) && n < 4000) begin
      @(negedge phy_clk);
      n++;
    end
    check(n < 4000, name, n, 4000);
  endtask

  initial begin
    int stall_n;
    int rd_base;
    int n;

    repeat (3) @(posedge phy_clk);
    #1 reset_phy_clk = 1'b0;
    @(negedge phy_clk);
    check(!in_ready && !out_valid && !local_write_req && !local_read_req && !local_burstbegin,
          "reset_ctrl", {in_ready, out_valid, local_write_req, local_read_req}, 0);
    check(local_address == '0 && local_wdata == '0, "reset_addr", local_wdata, 0);
    check(local_be == 8'hFF && local_size == 1'b1, "reset_be_size", {local_be, local_size},
          9'h1FF);
    check(level == '0 && !rdata_err, "reset_level_err", {level, rdata_err}, 0);

    // Calibration pending: input offered but nothing may move.
    repeat (50) begin
      @(negedge phy_clk);
      check(!in_ready && !local_write_req && !local_read_req, "init_hold",
            {in_ready, local_write_req, local_read_req}, 0);
    end
    local_init_done = 1'b1;
    wait_drained("seq_drain");
    check(level == '0, "seq_level_end", level, 0);

    // Controller stalls a write for a while.
    ready_mode = 1;
    acc_limit  = acc_cnt + 1;
    stall_n    = 0;
    repeat (14) begin
      @(negedge phy_clk);
      if (local_write_req) stall_n++;
    end
    check(stall_n >= 10, "stall_cycles", stall_n, 10);
    ready_mode = 0;
    wait_drained("stall_drain");

    // Random traffic.
    seq_mode   = 1'b0;
    ready_mode = 2;
    out_mode   = 2;
    in_mode    = 2;
    acc_limit  = acc_cnt + 150;
    wait_drained("random_drain");

    // Consumer stalled: reads stop at the credit limit and the ring fills.
    ready_mode = 0;
    out_mode   = 0;
    in_mode    = 1;
    rd_base    = rd_cnt;
    acc_limit  = acc_cnt + 40;
    repeat (300) @(negedge phy_clk);
    check(rd_cnt - rd_base == Cred, "credit_reads", rd_cnt - rd_base, Cred);
    check(level == (AW + 1)'(Ring) && !in_ready, "ring_full", level, Ring);
    check(!rdata_err, "credit_no_err", rdata_err, 0);
    out_mode = 1;
    wait_drained("credit_drain");

    // Reset with three reads in flight; their data returns afterwards.
    out_mode  = 0;
    hold_ret  = 1'b1;
    rd_base   = rd_cnt;
    acc_limit = acc_cnt + 3;
    n = 0;
    while (rd_cnt - rd_base < 3 && n < 200) begin
      @(negedge phy_clk);
      n++;
    end
    check(rd_cnt - rd_base == 3, "three_reads", rd_cnt - rd_base, 3);
    @(posedge phy_clk);
    #1;
    in_mode       = 0;
    reset_phy_clk = 1'b1;
    repeat (2) @(posedge phy_clk);
    #1;
    reset_phy_clk = 1'b0;
    hold_ret      = 1'b0;
    repeat (30) @(negedge phy_clk);
    check(ret_rd == ret_q.size(), "late_data_sent", ret_rd, ret_q.size());
    check(rdata_err == 1'b1, "late_data_err", rdata_err, 1);
    check(!out_valid && level == '0, "late_data_dropped", {out_valid, level}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
